// File: rtl/alu_exec_unit.sv
// Execution-stage ALU driven by the 4-bit ALU control command.
// Single-cycle ADD/SUB/AND/OR; MUL is an iterative shift-add with a start/busy/done handshake.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ctrl_command,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd1;
  localparam logic [3:0] CMD_MUL = 4'd2;
  localparam logic [3:0] CMD_AND = 4'd3;
  localparam logic [3:0] CMD_OR  = 4'd4;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     op_result;
  logic                 op_ovf;
  logic                 op_ill;

  always_comb begin
    acc_next = mplier[0] ? (acc + mcand) : acc;
  end

  always_comb begin
    op_result = '0;
    op_ovf    = 1'b0;
    op_ill    = 1'b0;
    case (ctrl_command)
      CMD_ADD: begin
        op_result = operand_a + operand_b;
        op_ovf    = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                    (op_result[WIDTH-1] != operand_a[WIDTH-1]);
      end
      CMD_SUB: begin
        op_result = operand_a - operand_b;
        op_ovf    = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                    (op_result[WIDTH-1] != operand_a[WIDTH-1]);
      end
      CMD_MUL: begin
        // Handled by the iterative path; never committed from here.
        op_result = '0;
      end
      CMD_AND: op_result = operand_a & operand_b;
      CMD_OR:  op_result = operand_a | operand_b;
      default: op_ill    = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (ctrl_command == CMD_MUL) begin
            mcand  <= {{WIDTH{1'b0}}, operand_a};
            mplier <= operand_b;
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH);
            busy   <= 1'b1;
            state  <= MUL_RUN;
          end else begin
            result   <= op_result;
            zero     <= (op_result == '0);
            overflow <= op_ovf;
            illegal  <= op_ill;
            done     <= 1'b1;
          end
        end
      end else begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CNT_W'(1);
        // Last iteration commits the product straight from the adder output.
        if (cnt == CNT_W'(1)) begin
          result   <= acc_next[WIDTH-1:0];
          zero     <= (acc_next[WIDTH-1:0] == '0);
          overflow <= |acc_next[2*WIDTH-1:WIDTH];
          illegal  <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: expected results are queued at issue
// time and popped when done is observed.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ctrl_command = 4'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy, done, zero, overflow, illegal;
  logic [31:0] result;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ctrl_command(ctrl_command),
    .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
    .result(result), .zero(zero), .overflow(overflow), .illegal(illegal)
  );

  function automatic exp_t model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    logic [31:0] r;
    e = '0;
    r = '0;
    p = '0;
    case (cmd)
      4'd0: begin r = a + b; e.overflow = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; e.overflow = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; e.overflow = |p[63:32]; end
      4'd3: r = a & b;
      4'd4: r = a | b;
      default: e.illegal = 1'b1;
    endcase
    e.result = r;
    e.zero   = (r == 32'd0);
    return e;
  endfunction

  // Drive a request at the current negedge and queue its expected outcome.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    start        = 1'b1;
    ctrl_command = cmd;
    operand_a    = a;
    operand_b    = b;
    sb.push_back(model(cmd, a, b));
  endtask

  task automatic test_reset();
    exp_t e;
    issue(4'd0, 32'd3, 32'd4);
    @(negedge clk);
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({done, result, zero, overflow, illegal} !== {1'b1, e}) begin
      errors++;
      $display("FAIL pre_reset_add: got done=%b result=%h z=%b o=%b i=%b, expected done=1 result=%h z=%b o=%b i=%b",
               done, result, zero, overflow, illegal, e.result, e.zero, e.overflow, e.illegal);
    end
    $display("txn reset_prep add: result=%h", result);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, zero, overflow, illegal} !== {1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b result=%h z=%b o=%b i=%b, expected 0 0 00000000 1 0 0",
               busy, done, result, zero, overflow, illegal);
    end
    $display("txn async_reset: busy=%b done=%b result=%h zero=%b", busy, done, result, zero);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_sub();
    logic [3:0]  cmds [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
    logic [31:0] as   [4] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] bs   [4] = '{32'd1, 32'd5, 32'd1, 32'd1};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(cmds[i], as[i], bs[i]);
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({done, busy, result, zero, overflow, illegal} !== {1'b1, 1'b0, e}) begin
        errors++;
        $display("FAIL add_sub[%0d]: got done=%b busy=%b result=%h z=%b o=%b i=%b, expected done=1 busy=0 result=%h z=%b o=%b i=%b",
                 i, done, busy, result, zero, overflow, illegal, e.result, e.zero, e.overflow, e.illegal);
      end
      $display("txn add_sub[%0d] cmd=%0d a=%h b=%h: result=%h z=%b o=%b", i, cmds[i], as[i], bs[i], result, zero, overflow);
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse[%0d]: got done=%b, expected 0", i, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  cmds [5];
    logic [31:0] as   [5];
    logic [31:0] bs   [5];
    exp_t e;
    cmds[0] = 4'd3; as[0] = 32'hF0F0F0F0; bs[0] = 32'hFF00FF00;
    cmds[1] = 4'd4; as[1] = 32'hF0F0F0F0; bs[1] = 32'hFF00FF00;
    for (int i = 2; i < 5; i++) begin
      cmds[i] = 4'($urandom_range(0, 4));
      if (cmds[i] == 4'd2) cmds[i] = 4'd1;
      as[i] = $urandom;
      bs[i] = $urandom;
    end
    issue(cmds[0], as[0], bs[0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) issue(cmds[i+1], as[i+1], bs[i+1]);
      else start = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({done, result, zero, overflow, illegal} !== {1'b1, e}) begin
        errors++;
        $display("FAIL b2b[%0d]: got done=%b result=%h z=%b o=%b i=%b, expected done=1 result=%h z=%b o=%b i=%b",
                 i, done, result, zero, overflow, illegal, e.result, e.zero, e.overflow, e.illegal);
      end
      $display("txn b2b[%0d] cmd=%0d: result=%h", i, cmds[i], result);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tail: got done=%b, expected 0", done);
    end
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit poke, input string tag);
    exp_t        e;
    int          done_k;
    int          busy_cnt;
    logic [31:0] held;
    held = result;
    issue(4'd2, a, b);
    @(negedge clk);
    start    = 1'b0;
    done_k   = -1;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    checks++;
    if (done !== 1'b0 || result !== held) begin
      errors++;
      $display("FAIL %s_hold: got done=%b result=%h, expected done=0 result=%h", tag, done, result, held);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (poke && k == 10) begin
        start = 1'b1; ctrl_command = 4'd0; operand_a = 32'd9; operand_b = 32'd9;
      end
      if (poke && k == 11) start = 1'b0;
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
    end
    start = 1'b0;
    checks++;
    if (done_k != 32 || busy_cnt != 32) begin
      errors++;
      $display("FAIL %s_latency: got done at cycle %0d with busy for %0d cycles, expected 32 and 32", tag, done_k, busy_cnt);
    end
    e = sb.pop_front();
    checks++;
    if ({busy, result, zero, overflow, illegal} !== {1'b0, e}) begin
      errors++;
      $display("FAIL %s_result: got busy=%b result=%h z=%b o=%b i=%b, expected busy=0 result=%h z=%b o=%b i=%b",
               tag, busy, result, zero, overflow, illegal, e.result, e.zero, e.overflow, e.illegal);
    end
    $display("txn %s a=%h b=%h: result=%h z=%b o=%b after %0d cycles", tag, a, b, result, zero, overflow, done_k);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: got done=%b busy=%b, expected 0 0", tag, done, busy);
    end
  endtask

  task automatic test_mul();
    run_mul(32'd1234, 32'd5678, 1'b1, "mul_small");
    run_mul(32'h00010000, 32'h00010000, 1'b0, "mul_ovf");
    run_mul(32'hFFFFFFFF, 32'h00000003, 1'b0, "mul_wrap");
  endtask

  task automatic test_illegal();
    exp_t e;
    issue(4'd9, 32'h12345678, 32'h9ABCDEF0);
    @(negedge clk);
    issue(4'd0, 32'd2, 32'd3);
    e = sb.pop_front();
    checks++;
    if ({done, result, zero, overflow, illegal} !== {1'b1, e}) begin
      errors++;
      $display("FAIL illegal_cmd: got done=%b result=%h z=%b o=%b i=%b, expected done=1 result=%h z=%b o=%b i=%b",
               done, result, zero, overflow, illegal, e.result, e.zero, e.overflow, e.illegal);
    end
    $display("txn illegal cmd=9: result=%h illegal=%b", result, illegal);
    @(negedge clk);
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({done, result, zero, overflow, illegal} !== {1'b1, e}) begin
      errors++;
      $display("FAIL after_illegal_add: got done=%b result=%h z=%b o=%b i=%b, expected done=1 result=%h z=%b o=%b i=%b",
               done, result, zero, overflow, illegal, e.result, e.zero, e.overflow, e.illegal);
    end
    $display("txn add after illegal: result=%h illegal=%b", result, illegal);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    exp_t e;
    int   spurious;
    issue(4'd2, 32'd1234, 32'd5678);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_mul_reset: got busy=%b done=%b, expected 0 0", busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL mid_mul_abort: got %0d cycles with done/busy high, expected 0", spurious);
    end
    $display("txn reset_mid_mul: aborted, busy=%b", busy);
    issue(4'd0, 32'd1, 32'd1);
    @(negedge clk);
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({done, result, zero, overflow, illegal} !== {1'b1, e}) begin
      errors++;
      $display("FAIL post_reset_add: got done=%b result=%h z=%b o=%b i=%b, expected done=1 result=%h z=%b o=%b i=%b",
               done, result, zero, overflow, illegal, e.result, e.zero, e.overflow, e.illegal);
    end
    $display("txn post_reset add: result=%h", result);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, result, zero, overflow, illegal} !== {1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL power_on_reset: got busy=%b done=%b result=%h z=%b o=%b i=%b, expected 0 0 00000000 1 0 0",
               busy, done, result, zero, overflow, illegal);
    end
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_mul();
    test_illegal();
    test_reset_mid_mul();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-stage ALU that consumes the 4-bit `ctrl_command` produced by the ALU control decoder. It is the receiving end of that command interface.
- Commands: ADD=0, SUB=1, MUL=2, AND=3, OR=4.
- ADD, SUB, AND and OR complete one cycle after acceptance. MUL is a multi-cycle shift-add operation.
- A start/busy/done handshake lets the pipeline control stall the EX stage while a multiply is in progress.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, width of the multiply iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to execute; sampled only in IDLE.
- ctrl_command  input  4  operation code from the ALU control decoder.
- operand_a  input  WIDTH  first source operand.
- operand_b  input  WIDTH  second source operand.
- busy  output  1  high while a MUL is iterating.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle on.
- result  output  WIDTH  registered result, held until the next done.
- zero  output  1  high when result == 0; held with result.
- overflow  output  1  arithmetic overflow; held with result.
- illegal  output  1  high when the completed command was undefined; held with result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State returns to IDLE.
  - busy, done, overflow and illegal go to 0.
  - result goes to 0, so zero reads 1.
  - The iteration counter and the internal multiplicand/multiplier/accumulator registers clear.
  - Reset asserted mid-MUL aborts the multiply with no done pulse.
- States:
  - IDLE: accepts a request.
  - MUL_RUN: performs the multiply iterations.
- Acceptance:
  - A request is accepted on a rising edge when state == IDLE and start == 1.
  - start is ignored in MUL_RUN; the request is not queued.
- Single-cycle ops (codes 0, 1, 3, 4):
  - On the accept edge, result, flags and done=1 are registered. Latency is 1 cycle.
  - State stays IDLE and busy stays 0.
- ADD / SUB:
  - Result is modulo 2^WIDTH.
  - overflow is signed two's-complement overflow: operands of the same sign with the opposite result sign for ADD; operands of differing sign with result sign != operand_a sign for SUB.
- AND / OR:
  - Bitwise operation; overflow = 0.
- MUL (code 2):
  - On the accept edge, operands are latched, the accumulator is cleared, counter = WIDTH, busy = 1, and state goes to MUL_RUN.
  - Each MUL_RUN edge performs one shift-add iteration on the 2*WIDTH-bit unsigned product and decrements the counter.
  - The edge on which the counter goes from 1 to 0 does the following:
    - writes the low WIDTH product bits to result;
    - sets overflow = 1 when any upper WIDTH bits are non-zero;
    - asserts done = 1 and clears busy;
    - returns the state to IDLE.
  - done is therefore visible WIDTH cycles after the accept edge.
  - Operand input changes during MUL_RUN have no effect.
- Undefined codes (5-15):
  - Handled like a single-cycle op: result = 0, zero = 1, overflow = 0, illegal = 1, with a done pulse.
- zero, illegal and overflow are updated only when done is asserted; otherwise they hold their values.
- done is high for exactly one cycle per accepted request.
- Back-to-back requests:
  - start may be high in the same cycle that done is high, because state is IDLE. The new request is accepted on that edge and produces its own done on the following cycle (single-cycle op) or WIDTH cycles later (MUL).
  - A continuous start with single-cycle ops yields done high every cycle.
- result holds its value between done pulses, including throughout MUL_RUN.

Test Plan:
- Reset: assert rst_n=0 mid-cycle, no clock edge needed -> busy=0, done=0, result=0, zero=1, overflow=0, illegal=0 immediately.
- ADD overflow: a=32'h7FFFFFFF, b=1, cmd=0, start for one cycle -> next cycle done=1, result=32'h80000000, overflow=1, zero=0. SUB: a=5, b=5, cmd=1 -> result=0, zero=1, overflow=0.
- AND then OR back-to-back with start held for two cycles: a=32'hF0F0F0F0, b=32'hFF00FF00 -> done high two consecutive cycles, result 32'hF000F000 then 32'hFFF0FFF0.
- MUL: a=1234, b=5678, cmd=2 -> busy=1 for 32 cycles, done exactly 32 cycles after the accept edge, result=7006652, overflow=0. Pulse start again at cycle 10 -> ignored. Also a=32'h00010000, b=32'h00010000 -> result=0, zero=1, overflow=1.
- Illegal code: cmd=4'd9 -> next cycle done=1, illegal=1, result=0. A following cmd=0 with a=2, b=3 -> illegal=0, result=5.
- Reset mid-MUL: assert rst_n=0 at cycle 15 of a multiply, then release -> no done pulse, busy=0, and the next ADD (a=1, b=1) completes normally with result=2.
